// File: rtl/stopwatch_pkg.sv
// Shared state encoding for the stopwatch lap controller and its helpers.
package stopwatch_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] IDLE   = 2'd0;
  localparam logic [STATE_W-1:0] RUN    = 2'd1;
  localparam logic [STATE_W-1:0] STOP   = 2'd2;
  localparam logic [STATE_W-1:0] RECALL = 2'd3;

endpackage

// File: rtl/stopwatch_lap_ctrl_tick_gen.sv
// Prescaler: counts 0..TICK_DIV-1 while run is high and emits a registered
// one-cycle tick on each wrap; the count is held while run is low.
module tick_gen #(
  parameter int TICK_DIV = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [CNT_W-1:0] presc_reg;
  logic             tick_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_reg <= '0;
      tick_reg  <= 1'b0;
    end else if (clr) begin
      presc_reg <= '0;
      tick_reg  <= 1'b0;
    end else if (run) begin
      if (presc_reg == LAST) begin
        presc_reg <= '0;
        tick_reg  <= 1'b1;
      end else begin
        presc_reg <= presc_reg + ONE;
        tick_reg  <= 1'b0;
      end
    end else begin
      // Holding the count keeps the fractional tick across stop/recall.
      tick_reg <= 1'b0;
    end
  end

  assign tick = tick_reg;

endmodule

// File: rtl/stopwatch_lap_ctrl.sv
// Stopwatch sequencing FSM: turns button pulses into counter strobes,
// lap ring-buffer write/read addressing and a display select.
module stopwatch_lap_ctrl
  import stopwatch_pkg::*;
#(
  parameter  int LAPS     = 4,
  parameter  int TICK_DIV = 100000,
  localparam int ADDR_W   = $clog2(LAPS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_stop,
  input  logic               lap,
  input  logic               recall,
  input  logic               clear,
  output logic               cnt_en,
  output logic               cnt_clr,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [ADDR_W-1:0]  rd_addr,
  output logic               disp_sel,
  output logic [ADDR_W:0]    lap_count,
  output logic               full,
  output logic [STATE_W-1:0] state
);

  localparam logic [ADDR_W:0]   LAPS_C = (ADDR_W + 1)'(LAPS);
  localparam logic [ADDR_W:0]   ONE_C  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] ONE_A  = ADDR_W'(1);

  logic [STATE_W-1:0] state_reg, state_next;
  logic [ADDR_W-1:0]  wr_ptr_reg, wr_addr_reg, rd_ptr_reg, recall_idx_reg;
  logic [ADDR_W:0]    lap_count_reg, lap_count_next, idx_inc;
  logic [ADDR_W-1:0]  newest;
  logic               cnt_clr_reg, wr_en_reg, disp_sel_reg, full_reg;
  logic               do_lap, rec_enter, rec_step;

  // Strict command priority: clear > start_stop > lap > recall.
  always_comb begin
    state_next = state_reg;
    do_lap     = 1'b0;
    rec_enter  = 1'b0;
    rec_step   = 1'b0;
    if (clear) begin
      state_next = IDLE;
    end else if (start_stop) begin
      state_next = (state_reg == RUN) ? STOP : RUN;
    end else if (lap) begin
      do_lap = (state_reg == RUN) || (state_reg == STOP);
    end else if (recall) begin
      if ((state_reg == STOP) && (lap_count_reg != '0)) begin
        state_next = RECALL;
        rec_enter  = 1'b1;
      end else if (state_reg == RECALL) begin
        rec_step = 1'b1;
      end
    end
  end

  assign newest         = wr_ptr_reg - ONE_A;
  assign idx_inc        = {1'b0, recall_idx_reg} + ONE_C;
  assign lap_count_next = (do_lap && (lap_count_reg != LAPS_C)) ? lap_count_reg + ONE_C
                                                                : lap_count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      cnt_clr_reg    <= 1'b0;
      wr_en_reg      <= 1'b0;
      wr_ptr_reg     <= '0;
      wr_addr_reg    <= '0;
      rd_ptr_reg     <= '0;
      recall_idx_reg <= '0;
      lap_count_reg  <= '0;
      full_reg       <= 1'b0;
      disp_sel_reg   <= 1'b0;
    end else if (clear) begin
      state_reg      <= IDLE;
      cnt_clr_reg    <= 1'b1;
      wr_en_reg      <= 1'b0;
      wr_ptr_reg     <= '0;
      wr_addr_reg    <= '0;
      rd_ptr_reg     <= '0;
      recall_idx_reg <= '0;
      lap_count_reg  <= '0;
      full_reg       <= 1'b0;
      disp_sel_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_clr_reg   <= 1'b0;
      wr_en_reg     <= do_lap;
      // Old pointer is presented with the strobe; the new one shows afterwards.
      wr_addr_reg   <= wr_ptr_reg;
      if (do_lap) wr_ptr_reg <= wr_ptr_reg + ONE_A;
      lap_count_reg <= lap_count_next;
      full_reg      <= (lap_count_next == LAPS_C);
      disp_sel_reg  <= (state_next == RECALL);
      // recall_idx counts how many laps back from the newest we are showing.
      if (rec_enter) begin
        rd_ptr_reg     <= newest;
        recall_idx_reg <= '0;
      end else if (rec_step) begin
        if (idx_inc == lap_count_reg) begin
          rd_ptr_reg     <= newest;
          recall_idx_reg <= '0;
        end else begin
          rd_ptr_reg     <= rd_ptr_reg - ONE_A;
          recall_idx_reg <= recall_idx_reg + ONE_A;
        end
      end
    end
  end

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .run  (state_reg == RUN),
    .clr  (clear),
    .tick (cnt_en)
  );

  assign cnt_clr   = cnt_clr_reg;
  assign wr_en     = wr_en_reg;
  assign wr_addr   = wr_addr_reg;
  assign rd_addr   = rd_ptr_reg;
  assign disp_sel  = disp_sel_reg;
  assign lap_count = lap_count_reg;
  assign full      = full_reg;
  assign state     = state_reg;

endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// Directed table-driven bench for stopwatch_lap_ctrl with LAPS=4, TICK_DIV=4.
module tb_stopwatch_lap_ctrl;

  logic       clk, reset;
  logic       start_stop, lap, recall, clear;
  logic       cnt_en, cnt_clr, wr_en, disp_sel, full;
  logic [1:0] wr_addr, rd_addr, state;
  logic [2:0] lap_count;

  stopwatch_lap_ctrl #(
    .LAPS    (4),
    .TICK_DIV(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start_stop(start_stop),
    .lap       (lap),
    .recall    (recall),
    .clear     (clear),
    .cnt_en    (cnt_en),
    .cnt_clr   (cnt_clr),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .rd_addr   (rd_addr),
    .disp_sel  (disp_sel),
    .lap_count (lap_count),
    .full      (full),
    .state     (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Packed order: en clr we wa[2] ra[2] ds lc[3] fu st[2]
  typedef struct {
    logic        ss, lp, rc, cl;
    logic [13:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [13:0] actual();
    return {cnt_en, cnt_clr, wr_en, wr_addr, rd_addr, disp_sel, lap_count, full, state};
  endfunction

  function automatic logic [13:0] pack(input int en, clr, we, wa, ra, ds, lc, fu, st);
    logic [13:0] p;
    p = {en[0], clr[0], we[0], wa[1:0], ra[1:0], ds[0], lc[2:0], fu[0], st[1:0]};
    return p;
  endfunction

  task automatic add(input int ss, lp, rc, cl,
                     input int en, clr, we, wa, ra, ds, lc, fu, st);
    vec_t v;
    v.ss  = ss[0];
    v.lp  = lp[0];
    v.rc  = rc[0];
    v.cl  = cl[0];
    v.exp = pack(en, clr, we, wa, ra, ds, lc, fu, st);
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [13:0] exp);
    logic [13:0] act;
    act = actual();
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got en=%b clr=%b we=%b wa=%0d ra=%0d ds=%b lc=%0d fu=%b st=%0d, expected en=%b clr=%b we=%b wa=%0d ra=%0d ds=%b lc=%0d fu=%b st=%0d",
               name, act[13], act[12], act[11], act[10:9], act[8:7], act[6], act[5:3], act[2], act[1:0],
               exp[13], exp[12], exp[11], exp[10:9], exp[8:7], exp[6], exp[5:3], exp[2], exp[1:0]);
    end else begin
      $display("[TB] %s ok: st=%0d en=%b we=%b wa=%0d ra=%0d lc=%0d", name, act[1:0], act[13], act[11],
               act[10:9], act[8:7], act[5:3]);
    end
  endtask

  initial begin
    reset = 1'b1; start_stop = 1'b0; lap = 1'b0; recall = 1'b0; clear = 1'b0;

    // ---- vector table: ss lp rc cl | en clr we wa ra ds lc fu st ----
    // Run: ticks at 4, 8, 12 cycles after entry
    add(1,0,0,0, 0,0,0,0,0,0,0,0,1);
    for (int i = 0; i < 3; i++) begin
      add(0,0,0,0, 0,0,0,0,0,0,0,0,1);
      add(0,0,0,0, 0,0,0,0,0,0,0,0,1);
      add(0,0,0,0, 0,0,0,0,0,0,0,0,1);
      add(0,0,0,0, 1,0,0,0,0,0,0,0,1);
    end
    // Stop 2 cycles after tick, wait 10, resume: tick 2 cycles later
    add(0,0,0,0, 0,0,0,0,0,0,0,0,1);
    add(1,0,0,0, 0,0,0,0,0,0,0,0,2);
    for (int i = 0; i < 10; i++) add(0,0,0,0, 0,0,0,0,0,0,0,0,2);
    add(1,0,0,0, 0,0,0,0,0,0,0,0,1);
    add(0,0,0,0, 0,0,0,0,0,0,0,0,1);
    add(0,0,0,0, 1,0,0,0,0,0,0,0,1);
    // Five laps in RUN, fourth coincides with a tick; ring wraps
    add(0,1,0,0, 0,0,1,0,0,0,1,0,1);
    add(0,1,0,0, 0,0,1,1,0,0,2,0,1);
    add(0,1,0,0, 0,0,1,2,0,0,3,0,1);
    add(0,1,0,0, 1,0,1,3,0,0,4,1,1);
    add(0,1,0,0, 0,0,1,0,0,0,4,1,1);
    add(0,0,0,0, 0,0,0,1,0,0,4,1,1);
    // clear + lap + start_stop together: clear wins
    add(1,1,0,1, 0,1,0,0,0,0,0,0,0);
    add(0,0,0,0, 0,0,0,0,0,0,0,0,0);
    add(0,1,0,0, 0,0,0,0,0,0,0,0,0);
    add(0,0,1,0, 0,0,0,0,0,0,0,0,0);
    // Three laps, stop (on a tick edge), recall x5
    add(1,0,0,0, 0,0,0,0,0,0,0,0,1);
    add(0,1,0,0, 0,0,1,0,0,0,1,0,1);
    add(0,1,0,0, 0,0,1,1,0,0,2,0,1);
    add(0,1,0,0, 0,0,1,2,0,0,3,0,1);
    add(1,0,0,0, 1,0,0,3,0,0,3,0,2);
    add(0,0,1,0, 0,0,0,3,2,1,3,0,3);
    add(0,0,1,0, 0,0,0,3,1,1,3,0,3);
    add(0,0,1,0, 0,0,0,3,0,1,3,0,3);
    add(0,0,1,0, 0,0,0,3,2,1,3,0,3);
    add(0,0,1,0, 0,0,0,3,1,1,3,0,3);
    add(0,1,0,0, 0,0,0,3,1,1,3,0,3);
    add(1,0,0,0, 0,0,0,3,1,0,3,0,1);
    add(0,0,0,0, 0,0,0,3,1,0,3,0,1);
    add(0,0,1,0, 0,0,0,3,1,0,3,0,1);
    // Clear, recall in STOP with no laps ignored, then single lap recall wrap
    add(0,0,0,1, 0,1,0,0,0,0,0,0,0);
    add(1,0,0,0, 0,0,0,0,0,0,0,0,1);
    add(1,0,0,0, 0,0,0,0,0,0,0,0,2);
    add(0,0,1,0, 0,0,0,0,0,0,0,0,2);
    add(0,0,0,0, 0,0,0,0,0,0,0,0,2);
    add(0,1,0,0, 0,0,1,0,0,0,1,0,2);
    add(0,0,1,0, 0,0,0,1,0,1,1,0,3);
    add(0,0,1,0, 0,0,0,1,0,1,1,0,3);
    // Resume: prescaler held at 1 through STOP/RECALL, tick after 3 cycles
    add(1,0,0,0, 0,0,0,1,0,0,1,0,1);
    add(0,0,0,0, 0,0,0,1,0,0,1,0,1);
    add(0,0,0,0, 0,0,0,1,0,0,1,0,1);
    add(0,0,0,0, 1,0,0,1,0,0,1,0,1);

    #12;
    check("reset", pack(0,0,0,0,0,0,0,0,0));
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      start_stop = vecs[i].ss;
      lap        = vecs[i].lp;
      recall     = vecs[i].rc;
      clear      = vecs[i].cl;
      @(posedge clk);
      #1;
      start_stop = 1'b0; lap = 1'b0; recall = 1'b0; clear = 1'b0;
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Async reset during a write-strobe cycle
    @(negedge clk);
    lap = 1'b1;
    @(posedge clk);
    #1;
    lap = 1'b0;
    check("lap_before_reset", pack(0,0,1,1,0,0,2,0,1));
    #1 reset = 1'b1;
    #1 check("async_reset_now", pack(0,0,0,0,0,0,0,0,0));
    @(posedge clk);
    #1 check("reset_held", pack(0,0,0,0,0,0,0,0,0));
    @(negedge clk);
    reset = 1'b0;
    start_stop = 1'b1;
    @(posedge clk);
    #1;
    start_stop = 1'b0;
    check("restart_after_reset", pack(0,0,0,0,0,0,0,0,1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
